sub_halt_ctrl: RTL and testbench
================================

Name: sub_halt_ctrl

Overview:
Main-CPU-side controller for the sub-CPU halt/attention protocol; the initiator end of the sub CPU's HALT/BA/BS handshake. It decodes main-CPU accesses to the $FD05 sub-control register and drives the sub CPU's SHALTn. It waits for the sub CPU's halt acknowledge (SHALTSTn), then grants the main CPU access to shared RAM. It also owns the sub BUSY flag and the cancel-IRQ latch.

Parameters:
SYNC_STAGES, 2, synchronizer depth for SHALTSTn (min 2).
HALT_TMO, 4096, cycles in HALT_REQ before HTMO status sets (0 disables).
EXTDET, 1'b1, constant returned in read bit0.

Ports:
CLK  in  1  system clock; all logic on rising edge.
RESETBn  in  1  asynchronous active-low reset.
MSTB  in  1  one-cycle strobe, main access to $FD05 valid this cycle.
MRWB  in  1  main R/W (1 = read), qualified by MSTB.
MDATA_in  in  8  main write data.
MDATA_out  out  8  read data, valid while MSTB & MRWB.
SHALTn  out  1  halt request to sub CPU, active low.
SHALTSTn  in  1  sub halt acknowledge (~(BA&BS)), asynchronous to CLK.
MSHRAMEN  out  1  shared-RAM grant to the main side.
SBUSYSET  in  1  sub-side strobe: set BUSY.
SBUSYCLR  in  1  sub-side strobe: clear BUSY.
SCANCELn  out  1  cancel-IRQ request to sub CPU, active low.
SCANACK  in  1  sub-side strobe acknowledging cancel.

Behaviour:
- Reset values: SHALTn=1, MSHRAMEN=0, SCANCELn=1, BUSY=1, HTMO=0, state RUN, pending=0, sync chain=1s, timeout counter=0.
- SHALTSTn passes through a SYNC_STAGES flop chain; hst = synchronized value. All decisions use hst only.
- Write (MSTB & ~MRWB):
  - bit7=1 requests halt.
  - bit7=0 requests release.
  - bit6=1 sets the cancel latch (SCANCELn=0).
  - Other bits are ignored.
- FSM:
  - RUN: SHALTn=1. A halt write, or pending=1, goes to HALT_REQ next cycle and clears pending.
  - HALT_REQ: SHALTn=0. Timeout counter increments. hst=0 on 2 consecutive cycles goes to HALTED. A release write goes to RELEASE.
  - HALTED: SHALTn=0, MSHRAMEN=1. A release write goes to RELEASE; MSHRAMEN drops in the same cycle the write is sampled (registered 0 next edge, no later).
  - RELEASE: SHALTn=1, MSHRAMEN=0. hst=1 goes to RUN. A halt write here sets pending=1; a release write clears pending.
- Halt write while in HALT_REQ or HALTED: no effect. Release write in RUN: no effect.
- MSHRAMEN is asserted only in HALTED. If hst rises while HALTED (spurious), MSHRAMEN drops immediately and the FSM returns to HALT_REQ.
- Timeout:
  - Counter clears on leaving HALT_REQ.
  - When the counter reaches HALT_TMO, HTMO=1 (sticky) and the counter saturates. The request stays asserted.
  - HTMO clears on any $FD05 write.
- Read (MSTB & MRWB): MDATA_out = {BUSY, HTMO, 1,1,1,1, halted, EXTDET}, where halted = (state==HALTED). Outside reads MDATA_out=8'hFF. Reads have no side effects.
- BUSY: SBUSYSET sets it, SBUSYCLR clears it; if both strobes are active in one cycle, set wins.
- Cancel latch: SCANACK releases it (SCANCELn=1). Simultaneous bit6 write and SCANACK: write wins (stays 0).
- Async reset mid-operation: all outputs return to reset values immediately, including SHALTn=1 and MSHRAMEN=0. The sub CPU is released.

Test Plan:
- Reset then read $FD05 -> MDATA_out=8'hBD (BUSY=1, HTMO=0, halted=0, EXTDET=1); SHALTn=1, SCANCELn=1.
- Write 8'h80; drive SHALTSTn low 3 cycles later -> SHALTn=0 the cycle after the write. MSHRAMEN=1 after sync plus 2 stable cycles. Read bit1=1.
- From HALTED write 8'h00 -> MSHRAMEN=0 at next edge, SHALTn=1. Hold SHALTSTn low 5 cycles then high -> RUN after sync; read bit1=0.
- In RELEASE (SHALTSTn still low) write 8'h80 -> SHALTn stays 1 until hst=1. Then RUN for 1 cycle, then HALT_REQ with SHALTn=0.
- HALT_TMO=16: write 8'h80, never ack -> bit6 reads 1 after 16 cycles in HALT_REQ and SHALTn stays 0. Write 8'h80 again -> bit6 clears.
- Write 8'h40 with SCANACK the same cycle -> SCANCELn=0; SCANACK next cycle -> SCANCELn=1. SBUSYSET+SBUSYCLR together -> BUSY=1. SBUSYCLR alone -> read bit7=0.

Source files
------------

// File: rtl/sub_halt_ctrl.sv
// Main-CPU side of the sub-CPU halt handshake: decodes $FD05, drives SHALTn,
// grants shared RAM once the sub CPU acknowledges, and owns BUSY / cancel-IRQ.
module sub_halt_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HALT_TMO    = 4096,
  parameter logic        EXTDET      = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_mstb,
  input  logic       i_mrwb,
  input  logic [7:0] i_mdata,
  output logic [7:0] o_mdata,
  output logic       o_shalt_n,
  input  logic       i_shaltst_n,
  output logic       o_mshramen,
  input  logic       i_sbusyset,
  input  logic       i_sbusyclr,
  output logic       o_scancel_n,
  input  logic       i_scanack
);

  localparam int            CW      = (HALT_TMO < 1) ? 1 : $clog2(HALT_TMO + 1);
  localparam logic [CW-1:0] TMO_VAL = CW'(HALT_TMO);
  localparam logic          TMO_EN  = (HALT_TMO != 0);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT_REQ,
    ST_HALTED,
    ST_RELEASE
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_shalt_n;
  logic                   r_mshramen;
  logic                   r_pending;
  logic                   r_ack_low;
  logic [CW-1:0]          r_tmo_cnt;
  logic                   r_htmo;
  logic                   r_busy;
  logic                   r_cancel;

  logic w_hst;
  logic w_wr;
  logic w_halt_wr;
  logic w_rel_wr;
  logic w_in_req;
  logic w_ack_done;
  logic w_leave_req;
  logic w_tmo_hit;
  logic w_halted;
  logic w_unused_mdata;

  assign w_hst          = r_sync[SYNC_STAGES-1];
  assign w_wr           = i_mstb & ~i_mrwb;
  assign w_halt_wr      = w_wr & i_mdata[7];
  assign w_rel_wr       = w_wr & ~i_mdata[7];
  assign w_in_req       = (r_state == ST_HALT_REQ);
  assign w_ack_done     = r_ack_low & ~w_hst;
  assign w_leave_req    = w_in_req & (w_rel_wr | w_ack_done);
  assign w_tmo_hit      = TMO_EN & w_in_req & (r_tmo_cnt == TMO_VAL - CW'(1));
  assign w_halted       = (r_state == ST_HALTED);
  assign w_unused_mdata = ^i_mdata[5:0];

  // SHALTSTn is asynchronous to the main clock; every decision uses only w_hst.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_shaltst_n};
    end
  end

  // Outputs are registered from the next state so the grant drops on the same edge a release is taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_RUN;
      r_shalt_n  <= 1'b1;
      r_mshramen <= 1'b0;
      r_pending  <= 1'b0;
      r_ack_low  <= 1'b0;
    end else begin
      r_ack_low <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_halt_wr || r_pending) begin
            r_state   <= ST_HALT_REQ;
            r_shalt_n <= 1'b0;
            r_pending <= 1'b0;
          end
        end
        ST_HALT_REQ: begin
          if (w_rel_wr) begin
            r_state   <= ST_RELEASE;
            r_shalt_n <= 1'b1;
          end else if (w_ack_done) begin
            r_state    <= ST_HALTED;
            r_mshramen <= 1'b1;
          end else begin
            r_ack_low <= ~w_hst;
          end
        end
        ST_HALTED: begin
          if (w_rel_wr) begin
            r_state    <= ST_RELEASE;
            r_shalt_n  <= 1'b1;
            r_mshramen <= 1'b0;
          end else if (w_hst) begin
            r_state    <= ST_HALT_REQ;
            r_mshramen <= 1'b0;
          end
        end
        ST_RELEASE: begin
          if (w_halt_wr) begin
            r_pending <= 1'b1;
          end else if (w_rel_wr) begin
            r_pending <= 1'b0;
          end
          if (w_hst) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_shalt_n  <= 1'b1;
          r_mshramen <= 1'b0;
        end
      endcase
    end
  end

  // Counts cycles spent requesting; saturates so HTMO fires exactly once per request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= '0;
    end else if (!w_in_req || w_leave_req) begin
      r_tmo_cnt <= '0;
    end else if (TMO_EN && (r_tmo_cnt != TMO_VAL)) begin
      r_tmo_cnt <= r_tmo_cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_htmo   <= 1'b0;
      r_busy   <= 1'b1;
      r_cancel <= 1'b0;
    end else begin
      if (w_wr) begin
        r_htmo <= 1'b0;
      end else if (w_tmo_hit) begin
        r_htmo <= 1'b1;
      end
      if (i_sbusyset) begin
        r_busy <= 1'b1;
      end else if (i_sbusyclr) begin
        r_busy <= 1'b0;
      end
      if (w_wr && i_mdata[6]) begin
        r_cancel <= 1'b1;
      end else if (i_scanack) begin
        r_cancel <= 1'b0;
      end
    end
  end

  assign o_mdata     = (i_mstb & i_mrwb) ? {r_busy, r_htmo, 4'hF, w_halted, EXTDET} : 8'hFF;
  assign o_shalt_n   = r_shalt_n;
  assign o_mshramen  = r_mshramen;
  assign o_scancel_n = ~r_cancel;

endmodule

// File: tb/tb_sub_halt_ctrl.sv
// Bench for sub_halt_ctrl: a cycle model built from the protocol rules is compared
// every cycle, and directed sequences pin key values with hand-computed literals.
module tb_sub_halt_ctrl;

  localparam int SYNC = 2;
  localparam int TMO  = 16;

  localparam int M_RUN    = 0;
  localparam int M_REQ    = 1;
  localparam int M_HALTED = 2;
  localparam int M_REL    = 3;

  logic       clk;
  logic       rstN;
  logic       mstb;
  logic       mrwb;
  logic [7:0] wData;
  logic [7:0] rData;
  logic       shaltN;
  logic       shaltstN;
  logic       shramEn;
  logic       busySet;
  logic       busyClr;
  logic       cancelN;
  logic       canAck;

  int checkCount = 0;
  int errCount   = 0;

  int mMode;
  bit mPend;
  bit mHtmo;
  bit mBusy;
  bit mCancel;
  int mLow;
  int mReqCycles;
  bit samp[$];

  sub_halt_ctrl #(
    .SYNC_STAGES(SYNC),
    .HALT_TMO   (TMO),
    .EXTDET     (1'b1)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_mstb     (mstb),
    .i_mrwb     (mrwb),
    .i_mdata    (wData),
    .o_mdata    (rData),
    .o_shalt_n  (shaltN),
    .i_shaltst_n(shaltstN),
    .o_mshramen (shramEn),
    .i_sbusyset (busySet),
    .i_sbusyclr (busyClr),
    .o_scancel_n(cancelN),
    .i_scanack  (canAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: actual=%02h required=%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the synchronized ack seen at edge n is the raw input sampled SYNC edges earlier.
  always @(posedge clk or negedge rstN) begin
    bit hst;
    bit wr;
    bit hw;
    bit rw;
    bit tmoHit;
    if (!rstN) begin
      mMode      = M_RUN;
      mPend      = 1'b0;
      mHtmo      = 1'b0;
      mBusy      = 1'b1;
      mCancel    = 1'b0;
      mLow       = 0;
      mReqCycles = 0;
      samp.delete();
    end else begin
      hst = (samp.size() >= SYNC) ? samp[samp.size() - SYNC] : 1'b1;
      samp.push_back(shaltstN);
      wr     = mstb & ~mrwb;
      hw     = wr & wData[7];
      rw     = wr & ~wData[7];
      tmoHit = 1'b0;
      case (mMode)
        M_RUN: begin
          if (hw || mPend) begin
            mMode      = M_REQ;
            mPend      = 1'b0;
            mLow       = 0;
            mReqCycles = 0;
          end
        end
        M_REQ: begin
          if (mReqCycles < TMO) begin
            mReqCycles++;
            tmoHit = (mReqCycles == TMO);
          end
          if (rw) begin
            mMode = M_REL;
          end else begin
            mLow = hst ? 0 : mLow + 1;
            if (mLow >= 2) mMode = M_HALTED;
          end
        end
        M_HALTED: begin
          if (rw) begin
            mMode = M_REL;
          end else if (hst) begin
            mMode      = M_REQ;
            mLow       = 0;
            mReqCycles = 0;
          end
        end
        default: begin
          if (hw) mPend = 1'b1;
          else if (rw) mPend = 1'b0;
          if (hst) mMode = M_RUN;
        end
      endcase
      if (wr) mHtmo = 1'b0;
      else if (tmoHit) mHtmo = 1'b1;
      if (busySet) mBusy = 1'b1;
      else if (busyClr) mBusy = 1'b0;
      if (wr && wData[6]) mCancel = 1'b1;
      else if (canAck) mCancel = 1'b0;
    end
  end

  function automatic logic [7:0] modelRead();
    bit halted;
    halted = (mMode == M_HALTED);
    return (mstb && mrwb) ? {mBusy, mHtmo, 4'hF, halted, 1'b1} : 8'hFF;
  endfunction

  always @(negedge clk) begin
    bit reqActive;
    if (rstN) begin
      reqActive = (mMode == M_REQ) || (mMode == M_HALTED);
      checkOutput("cyc_shalt_n", {7'b0, shaltN}, {7'b0, !reqActive});
      checkOutput("cyc_mshramen", {7'b0, shramEn}, {7'b0, mMode == M_HALTED});
      checkOutput("cyc_scancel_n", {7'b0, cancelN}, {7'b0, !mCancel});
      checkOutput("cyc_mdata", rData, modelRead());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic stb, input logic rw, input logic [7:0] d,
                               input logic bset, input logic bclr, input logic ack);
    @(posedge clk);
    #2;
    mstb    = stb;
    mrwb    = rw;
    wData   = d;
    busySet = bset;
    busyClr = bclr;
    canAck  = ack;
    @(posedge clk);
    #2;
    mstb    = 1'b0;
    mrwb    = 1'b0;
    busySet = 1'b0;
    busyClr = 1'b0;
    canAck  = 1'b0;
  endtask

  task automatic doWrite(input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doRead(input logic [7:0] exp, input string name);
    @(posedge clk);
    #2;
    mstb = 1'b1;
    mrwb = 1'b1;
    #1;
    checkOutput(name, rData, exp);
    @(posedge clk);
    #2;
    mstb = 1'b0;
    mrwb = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN     = 1'b0;
    mstb     = 1'b0;
    mrwb     = 1'b0;
    wData    = 8'h00;
    shaltstN = 1'b1;
    busySet  = 1'b0;
    busyClr  = 1'b0;
    canAck   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rstN = 1'b1;

    // Reset state.
    checkOutput("rst_shalt_n", {7'b0, shaltN}, 8'h01);
    checkOutput("rst_scancel_n", {7'b0, cancelN}, 8'h01);
    checkOutput("rst_mshramen", {7'b0, shramEn}, 8'h00);
    doRead(8'hBD, "rst_read");

    // Halt request, ack low three cycles after the write, grant after sync + 2 stable cycles.
    doWrite(8'h80);
    checkOutput("halt_shalt_n", {7'b0, shaltN}, 8'h00);
    tick(2);
    shaltstN = 1'b0;
    tick(3);
    checkOutput("grant_not_yet", {7'b0, shramEn}, 8'h00);
    tick(1);
    checkOutput("grant_on", {7'b0, shramEn}, 8'h01);
    doRead(8'hBF, "halted_read");

    // Release from HALTED: grant drops on the very next edge.
    doWrite(8'h00);
    checkOutput("rel_grant_off", {7'b0, shramEn}, 8'h00);
    checkOutput("rel_shalt_n", {7'b0, shaltN}, 8'h01);
    tick(5);
    shaltstN = 1'b1;
    tick(3);
    doRead(8'hBD, "run_read");

    // Halt write while in RELEASE is held pending until the sub drops its ack.
    doWrite(8'h80);
    shaltstN = 1'b0;
    tick(4);
    checkOutput("rehalt_grant", {7'b0, shramEn}, 8'h01);
    doWrite(8'h00);
    checkOutput("release_shalt_n", {7'b0, shaltN}, 8'h01);
    doWrite(8'h80);
    checkOutput("pend_shalt_n_a", {7'b0, shaltN}, 8'h01);
    tick(3);
    checkOutput("pend_shalt_n_b", {7'b0, shaltN}, 8'h01);
    shaltstN = 1'b1;
    tick(3);
    checkOutput("pend_run_shalt_n", {7'b0, shaltN}, 8'h01);
    tick(1);
    checkOutput("pend_req_shalt_n", {7'b0, shaltN}, 8'h00);

    // Never acknowledged: HTMO appears after 16 request cycles, request stays on.
    tick(14);
    doRead(8'hBD, "tmo_before");
    doRead(8'hFD, "tmo_after");
    checkOutput("tmo_shalt_n", {7'b0, shaltN}, 8'h00);
    doWrite(8'h80);
    doRead(8'hBD, "tmo_cleared");
    doWrite(8'h00);
    tick(2);

    // Cancel latch and BUSY flag priorities.
    applyStimulus(1'b1, 1'b0, 8'h40, 1'b0, 1'b0, 1'b1);
    checkOutput("cancel_set", {7'b0, cancelN}, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("cancel_ack", {7'b0, cancelN}, 8'h01);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    doRead(8'hBD, "busy_both");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    doRead(8'h3D, "busy_clr");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    doRead(8'hBD, "busy_set");

    // Spurious ack release while HALTED drops the grant and re-requests.
    doWrite(8'h80);
    shaltstN = 1'b0;
    tick(4);
    checkOutput("spur_grant_on", {7'b0, shramEn}, 8'h01);
    shaltstN = 1'b1;
    tick(2);
    checkOutput("spur_grant_hold", {7'b0, shramEn}, 8'h01);
    tick(1);
    checkOutput("spur_grant_off", {7'b0, shramEn}, 8'h00);
    checkOutput("spur_shalt_n", {7'b0, shaltN}, 8'h00);
    shaltstN = 1'b0;
    tick(4);
    checkOutput("spur_regrant", {7'b0, shramEn}, 8'h01);
    doWrite(8'hC0);
    checkOutput("halted_cancel", {7'b0, cancelN}, 8'h00);
    checkOutput("halted_stays", {7'b0, shramEn}, 8'h01);

    // Asynchronous reset mid-operation releases everything at once.
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("arst_shalt_n", {7'b0, shaltN}, 8'h01);
    checkOutput("arst_mshramen", {7'b0, shramEn}, 8'h00);
    checkOutput("arst_scancel_n", {7'b0, cancelN}, 8'h01);
    @(posedge clk);
    #2;
    shaltstN = 1'b1;
    rstN     = 1'b1;
    tick(2);
    doRead(8'hBD, "arst_read");
    tick(2);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
